// File: rtl/pc_pkg.sv
// pc_pkg: shared constants, pointer-width helper and next-pc source enum for the fetch PC generator.
package pc_pkg;
  localparam int unsigned DEF_INC = 4;
  localparam logic [63:0] DEF_RESET_PC = 64'h0;
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  typedef enum logic [2:0] {SRC_RESET, SRC_REDIRECT, SRC_RET, SRC_HOLD, SRC_SEQ} pc_src_e;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; overwrites the oldest entry when full.
module ras_stack import pc_pkg::*; #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full,
  output logic             underflow
);
  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = PW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_tp, w_tp_nxt, w_wr_ptr;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic r_und;
  assign empty = r_cnt == '0;
  assign full = r_cnt == CW'(DEPTH);
  assign top_data = r_mem[r_tp];
  assign underflow = r_und;
  // push with pop replaces the top in place; push alone writes above it
  always_comb begin
    w_wr_ptr = pop ? r_tp : r_tp + 1'b1;
    w_tp_nxt = (push && !pop) ? r_tp + 1'b1 : (pop && !push && !empty) ? r_tp - 1'b1 : r_tp;
    w_cnt_nxt = (push && pop) ? (empty ? CW'(1) : r_cnt) :
                push ? (full ? r_cnt : r_cnt + 1'b1) :
                (pop && !empty) ? r_cnt - 1'b1 : r_cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tp <= '0;
      r_cnt <= '0;
      r_und <= 1'b0;
    end else begin
      r_tp <= w_tp_nxt;
      r_cnt <= w_cnt_nxt;
      r_und <= pop && empty;
    end
  end
  always_ff @(posedge clk) if (!reset && push) r_mem[w_wr_ptr] <= push_data;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with stall hold, prioritised redirect and RAS-predicted returns.
module pc_gen import pc_pkg::*; #(
  parameter int unsigned      WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DEF_RESET_PC),
  parameter int unsigned      INC       = DEF_INC,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             ret,
  input  logic [WIDTH-1:0] ret_pc,
  input  logic             push,
  input  logic [WIDTH-1:0] push_addr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow,
  output logic             misaligned
);
  pc_src_e w_src;
  logic [WIDTH-1:0] r_pc, w_top, w_tgt, w_pc_nxt;
  logic r_mis;
  ras_stack #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .reset(reset), .push(push), .pop(ret), .push_data(push_addr),
    .top_data(w_top), .empty(ras_empty), .full(ras_full), .underflow(ras_underflow)
  );
  assign pc = r_pc;
  assign pc_next_seq = r_pc + WIDTH'(INC);
  assign misaligned = r_mis;
  // redirect outranks ret for the target, but the RAS still pops on ret
  always_comb begin
    w_src = reset ? SRC_RESET : redirect ? SRC_REDIRECT : ret ? SRC_RET : stall ? SRC_HOLD : SRC_SEQ;
    w_tgt = redirect ? redirect_pc : ras_empty ? ret_pc : w_top;
    w_pc_nxt = (w_src == SRC_RESET) ? RESET_PC :
               (w_src == SRC_HOLD) ? r_pc :
               (w_src == SRC_SEQ) ? pc_next_seq : {w_tgt[WIDTH-1:2], 2'b00};
  end
  always_ff @(posedge clk) begin
    r_pc <= w_pc_nxt;
    r_mis <= (w_src == SRC_REDIRECT || w_src == SRC_RET) && (w_tgt[1:0] != 2'b00);
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and randomized checks of pc_gen against a queue-based reference model.
module tb_pc_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, stall, redirect, ret, push;
  logic [63:0] redirect_pc, ret_pc, push_addr, pc, pc_next_seq;
  logic ras_empty, ras_full, ras_underflow, misaligned;
  logic reset8, stall8, z1;
  logic [7:0] z8, pc8, seq8;
  logic e8, f8, u8, m8;
  int n_chk = 0, n_pass = 0;
  logic [63:0] m_pc;
  logic [63:0] m_q[$];
  bit m_und, m_mis;

  pc_gen dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ret(ret), .ret_pc(ret_pc), .push(push), .push_addr(push_addr), .pc(pc),
    .pc_next_seq(pc_next_seq), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_underflow(ras_underflow), .misaligned(misaligned)
  );

  pc_gen #(.WIDTH(8), .RESET_PC(8'hF4)) dut8 (
    .clk(clk), .reset(reset8), .stall(stall8), .redirect(z1), .redirect_pc(z8),
    .ret(z1), .ret_pc(z8), .push(z1), .push_addr(z8), .pc(pc8),
    .pc_next_seq(seq8), .ras_empty(e8), .ras_full(f8),
    .ras_underflow(u8), .misaligned(m8)
  );

  task automatic do_reset();
    {stall, redirect, ret, push} = '0;
    {redirect_pc, ret_pc, push_addr} = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_pc = 64'h0; m_q.delete(); m_und = 0; m_mis = 0;
  endtask

  // drives one cycle of controls and advances the reference model
  task automatic step(input bit s, input bit rd, input logic [63:0] rpc, input bit rt,
                      input logic [63:0] rtpc, input bit ps, input logic [63:0] pa);
    logic [63:0] tgt;
    bit emp;
    stall = s; redirect = rd; redirect_pc = rpc; ret = rt; ret_pc = rtpc; push = ps; push_addr = pa;
    emp = (m_q.size() == 0);
    tgt = rd ? rpc : (emp ? rtpc : m_q[m_q.size()-1]);
    m_und = rt && emp;
    m_mis = (rd || rt) && (tgt[1:0] != 2'b00);
    if (rd || rt) m_pc = tgt & ~64'h3;
    else if (!s) m_pc = m_pc + 64'd4;
    if (ps && rt) begin
      if (emp) m_q.push_back(pa);
      else m_q[m_q.size()-1] = pa;
    end else if (ps) begin
      if (m_q.size() == 4) void'(m_q.pop_front());
      m_q.push_back(pa);
    end else if (rt && !emp) void'(m_q.pop_back());
    @(posedge clk); #1;
    {stall, redirect, ret, push} = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (pc !== 64'h0) $display("FAIL reset_pc got=%h exp=0", pc); else n_pass++;
    n_chk++; if (pc_next_seq !== 64'h4) $display("FAIL reset_seq got=%h exp=4", pc_next_seq); else n_pass++;
    n_chk++; if ({ras_empty, ras_full, ras_underflow, misaligned} !== 4'b1000)
      $display("FAIL reset_flags got=%b exp=1000", {ras_empty, ras_full, ras_underflow, misaligned}); else n_pass++;
  endtask

  task automatic test_seq();
    logic [63:0] exp_pc [3] = '{64'h4, 64'h8, 64'hC};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      n_chk++; if (pc !== exp_pc[i]) $display("FAIL seq_%0d got=%h exp=%h", i, pc, exp_pc[i]); else n_pass++;
    end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      n_chk++; if (pc !== 64'h8) $display("FAIL stall_hold_%0d got=%h exp=8", i, pc); else n_pass++;
    end
    step(1, 1, 64'h40, 0, 0, 0, 0);
    n_chk++; if (pc !== 64'h40) $display("FAIL stall_redirect got=%h exp=40", pc); else n_pass++;
  endtask

  task automatic test_ras_basic();
    do_reset();
    step(0, 0, 0, 0, 0, 1, 64'h10);
    step(0, 0, 0, 0, 0, 1, 64'h20);
    step(0, 0, 0, 1, 64'h99C, 0, 0);
    n_chk++; if (pc !== 64'h20 || ras_underflow !== 1'b0) $display("FAIL ret1 pc=%h und=%b exp 20/0", pc, ras_underflow); else n_pass++;
    step(0, 0, 0, 1, 64'h99C, 0, 0);
    n_chk++; if (pc !== 64'h10 || ras_underflow !== 1'b0) $display("FAIL ret2 pc=%h und=%b exp 10/0", pc, ras_underflow); else n_pass++;
    n_chk++; if (ras_empty !== 1'b1) $display("FAIL ret2_empty got=%b exp=1", ras_empty); else n_pass++;
    step(0, 0, 0, 1, 64'h99C, 0, 0);
    n_chk++; if (pc !== 64'h99C || ras_underflow !== 1'b1) $display("FAIL ret3 pc=%h und=%b exp 99c/1", pc, ras_underflow); else n_pass++;
    step(0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (ras_underflow !== 1'b0) $display("FAIL und_pulse got=%b exp=0", ras_underflow); else n_pass++;
  endtask

  task automatic test_ras_overflow();
    logic [63:0] exp_pc [4] = '{64'h14, 64'h10, 64'hC, 64'h8};
    do_reset();
    for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, 0, 1, 64'(4 * i));
    n_chk++; if (ras_full !== 1'b1) $display("FAIL ovf_full got=%b exp=1", ras_full); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 64'hDEAD0, 0, 0);
      n_chk++; if (pc !== exp_pc[i]) $display("FAIL ovf_ret_%0d got=%h exp=%h", i, pc, exp_pc[i]); else n_pass++;
    end
    n_chk++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) $display("FAIL ovf_drained empty=%b full=%b exp 1/0", ras_empty, ras_full); else n_pass++;
  endtask

  task automatic test_push_ret();
    do_reset();
    step(0, 0, 0, 0, 0, 1, 64'h30);
    step(0, 0, 0, 1, 64'h700, 1, 64'h50);
    n_chk++; if (pc !== 64'h30 || ras_empty !== 1'b0) $display("FAIL pushret pc=%h empty=%b exp 30/0", pc, ras_empty); else n_pass++;
    step(0, 0, 0, 1, 64'h700, 0, 0);
    n_chk++; if (pc !== 64'h50 || ras_empty !== 1'b1) $display("FAIL pushret_top pc=%h empty=%b exp 50/1", pc, ras_empty); else n_pass++;
  endtask

  task automatic test_misaligned();
    do_reset();
    step(0, 1, 64'h42, 0, 0, 0, 0);
    n_chk++; if (pc !== 64'h40 || misaligned !== 1'b1) $display("FAIL mis_redir pc=%h mis=%b exp 40/1", pc, misaligned); else n_pass++;
    step(0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (misaligned !== 1'b0) $display("FAIL mis_pulse got=%b exp=0", misaligned); else n_pass++;
    step(0, 0, 0, 0, 0, 1, 64'h63);
    step(0, 0, 0, 1, 0, 0, 0);
    n_chk++; if (pc !== 64'h60 || misaligned !== 1'b1) $display("FAIL mis_ret pc=%h mis=%b exp 60/1", pc, misaligned); else n_pass++;
    step(0, 0, 0, 0, 0, 1, 64'h60);
    step(0, 1, 64'h80, 1, 0, 0, 0);
    n_chk++; if (pc !== 64'h80 || ras_empty !== 1'b1) $display("FAIL redir_ret pc=%h empty=%b exp 80/1", pc, ras_empty); else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 64'h100 + 64'(i));
    reset = 1'b1; redirect = 1'b1; redirect_pc = 64'h500; ret = 1'b1; push = 1'b1; push_addr = 64'h77;
    @(posedge clk); #1;
    n_chk++; if (pc !== 64'h0 || ras_empty !== 1'b1 || misaligned !== 1'b0)
      $display("FAIL mid_reset pc=%h empty=%b mis=%b exp 0/1/0", pc, ras_empty, misaligned); else n_pass++;
    do_reset();
  endtask

  task automatic test_wrap8();
    logic [7:0] exp_pc [4] = '{8'hF8, 8'hFC, 8'h00, 8'h04};
    stall8 = 1'b0; reset8 = 1'b1;
    @(posedge clk); #1;
    reset8 = 1'b0;
    n_chk++; if (pc8 !== 8'hF4 || seq8 !== 8'hF8 || e8 !== 1'b1) $display("FAIL w8_reset pc=%h seq=%h empty=%b exp f4/f8/1", pc8, seq8, e8); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_chk++; if (pc8 !== exp_pc[i]) $display("FAIL w8_seq_%0d got=%h exp=%h", i, pc8, exp_pc[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(3) == 0, $urandom_range(9) == 0, {$urandom, $urandom},
           $urandom_range(6) == 0, {$urandom, $urandom}, $urandom_range(4) == 0, {$urandom, $urandom});
      errs = 0;
      n_chk++; if (pc !== m_pc) begin errs++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, pc, m_pc); end else n_pass++;
      n_chk++; if (pc_next_seq !== m_pc + 64'd4) $display("FAIL rnd_seq cyc=%0d got=%h exp=%h", i, pc_next_seq, m_pc + 64'd4); else n_pass++;
      n_chk++; if (ras_empty !== (m_q.size() == 0) || ras_full !== (m_q.size() == 4))
        $display("FAIL rnd_ras cyc=%0d empty=%b full=%b exp_cnt=%0d", i, ras_empty, ras_full, m_q.size()); else n_pass++;
      n_chk++; if (ras_underflow !== m_und || misaligned !== m_mis)
        $display("FAIL rnd_pulse cyc=%0d und=%b mis=%b exp %b/%b", i, ras_underflow, misaligned, m_und, m_mis); else n_pass++;
      if (errs != 0) m_pc = pc;
    end
  endtask

  initial begin
    z1 = 1'b0; z8 = 8'h0; reset8 = 1'b1; stall8 = 1'b0;
    test_reset();
    test_seq();
    test_stall_redirect();
    test_ras_basic();
    test_ras_overflow();
    test_push_ret();
    test_misaligned();
    test_mid_reset();
    test_wrap8();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-stage program-counter generator for the pipelined CPU. It replaces the fixed 64-bit "PC + 4 or branch target" counter with configurable width, reset vector and increment. It adds a stall hold, prioritised redirect, and an internal return-address stack (RAS) for call/return prediction. It sits at the head of the IF stage and drives the instruction-memory address every cycle.

## Interface
Parameters:
- WIDTH, 64, PC and address width in bits (≥8)
- RESET_PC, 0, value loaded into pc on reset
- INC, 4, sequential increment in bytes
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high; reset reset, synchronous, active-high; clock clk
- stall  in  1  hold pc (IF/ID stall)
- redirect  in  1  resolved branch taken; load redirect_pc
- redirect_pc  in  WIDTH  branch target
- ret  in  1  return instruction; redirect to RAS top, pop
- ret_pc  in  WIDTH  fallback return target (link register value) used when RAS empty
- push  in  1  call instruction; push push_addr onto RAS
- push_addr  in  WIDTH  return address to push (call address + INC)
- pc  out  WIDTH  current fetch address (registered)
- pc_next_seq  out  WIDTH  pc + INC (combinational)
- ras_empty  out  1  RAS count == 0
- ras_full  out  1  RAS count == RAS_DEPTH
- ras_underflow  out  1  one-cycle pulse: ret taken while RAS empty
- misaligned  out  1  one-cycle pulse: selected non-sequential target had low 2 bits ≠ 0

## Operation
- Next-pc priority, highest first: reset → RESET_PC; redirect → redirect_pc; ret → RAS top (or ret_pc if empty); stall → pc unchanged; else pc + INC.
- redirect and ret both override stall; a resolved branch is never lost.
- redirect and ret in the same cycle: redirect wins for pc, but the RAS pop still occurs.
- All additions are modulo 2^WIDTH; pc wraps from 2^WIDTH−INC to 0 with no flag.
- Misalignment: if the chosen redirect/ret target has bits [1:0] ≠ 0, pc loads the target with bits [1:0] forced to 0 and misaligned pulses for one cycle.
- RAS is circular with top pointer tp and count cnt (0..RAS_DEPTH):
  - Push only: write push_addr at tp+1, advance tp, cnt = min(cnt+1, RAS_DEPTH). When full, the oldest entry is overwritten silently.
  - Pop only (ret): read entry at tp, retreat tp, cnt−1. When empty, use ret_pc, leave tp/cnt unchanged, and pulse ras_underflow.
  - Push and ret in the same cycle: the target is the old top (or ret_pc if empty). The top entry is replaced by push_addr. tp is unchanged. cnt becomes max(cnt,1).
- Pops and pushes act regardless of stall; the issuing stage gates them.

## Timing
- Reset values: pc = RESET_PC; pc_next_seq = RESET_PC+INC; RAS cnt = 0, tp = 0; ras_empty = 1; ras_full = 0; ras_underflow = 0; misaligned = 0. RAS storage contents are don't-care.
- pc updates one cycle after its controls are sampled. Redirect/ret asserted in cycle n gives the new pc visible in cycle n+1.
- ras_underflow and misaligned are registered and high during cycle n+1 only.
- ras_empty and ras_full are derived from registered cnt and reflect push/pop effects the cycle after.
- reset asserted mid-operation overrides all inputs that cycle and clears the RAS.

## Structure
- Shared package pc_pkg:
  - default INC and RESET_PC constants
  - a clog2-based pointer-width localparam helper
  - an enum for next-pc source (SRC_RESET, SRC_REDIRECT, SRC_RET, SRC_HOLD, SRC_SEQ), used for debug visibility
- Sub-module ras_stack holds storage, tp and cnt. Its interface is push/pop/push_data/top_data/empty/full/underflow.
- pc_gen instantiates ras_stack plus the priority mux and pc register.

## Test plan
- Reset then run 3 cycles with no controls → pc 0, 4, 8, 12; with RESET_PC=0x100 → 0x100, 0x104.
- stall held 2 cycles at pc=8, then redirect_pc=0x40 with stall still high → pc stays 8, 8, then 0x40 next cycle.
- Push 0x10, 0x20; then ret twice; then ret again with ret_pc=0x99C → pc 0x20, 0x10, 0x99C; ras_underflow pulses on the third ret only; ras_empty=1 after the second ret.
- RAS_DEPTH=4, push 1..5 (×4 addresses 0x4..0x14) → ras_full=1; then 4 rets → 0x14, 0x10, 0xC, 0x8 (0x4 lost).
- Simultaneous push 0x50 and ret with top 0x30 → pc=0x30, new top 0x50, cnt unchanged.
- redirect_pc=0x42 → pc=0x40, misaligned pulse; WIDTH=8 at pc=0xFC sequential → pc=0x00; reset asserted mid-stack → pc=RESET_PC, ras_empty=1.
